setcc_arbiter: RTL and testbench

- Shares one combinational setcc condition-code unit between two requesters.
- Arbitrates round-robin and latches the winner's operands and opcode.
- Drives the setcc inputs for one execute cycle, then captures result and c/z/n/v flags.
- Returns result and flags to the winner on a valid/ready response channel.
- Sits between requesting sequencers and the setcc datapath instance.

---
 rtl/setcc_arbiter.sv | 146 ++++++++++++++
 tb/tb_setcc_arbiter.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/setcc_arbiter.sv
// Round-robin arbiter sharing one combinational setcc unit between two requesters.
// Grant in IDLE, drive the unit for one EXEC cycle, then hold the captured response in RESP.
module setcc_arbiter #(
    parameter int unsigned width = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [width-1:0] req0_op1,
    input  logic [width-1:0] req0_op2,
    input  logic [1:0]       req0_opc,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [width-1:0] req1_op1,
    input  logic [width-1:0] req1_op2,
    input  logic [1:0]       req1_opc,
    output logic [width-1:0] alu_op1,
    output logic [width-1:0] alu_op2,
    output logic             alu_add,
    output logic             alu_sub,
    output logic             alu_cmp,
    input  logic [width:0]   alu_result,
    input  logic             alu_c,
    input  logic             alu_z,
    input  logic             alu_n,
    input  logic             alu_v,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [width:0]   rsp_result,
    output logic [3:0]       rsp_flags,
    output logic             rsp_err
);

    typedef enum logic [1:0] {StIdle, StExec, StResp} state_t;

    localparam logic [1:0] OpcAdd = 2'b00;
    localparam logic [1:0] OpcSub = 2'b01;
    localparam logic [1:0] OpcCmp = 2'b10;
    localparam logic [1:0] OpcRsv = 2'b11;

    state_t           r_state;
    logic             r_last_grant;
    logic [1:0]       r_opc;
    logic             r_id;
    logic [width-1:0] r_alu_op1;
    logic [width-1:0] r_alu_op2;
    logic             r_alu_add;
    logic             r_alu_sub;
    logic             r_alu_cmp;
    logic             r_rsp_valid;
    logic             r_rsp_id;
    logic [width:0]   r_rsp_result;
    logic [3:0]       r_rsp_flags;
    logic             r_rsp_err;

    logic             w_grant;
    logic             w_grant_id;
    logic [width-1:0] w_op1;
    logic [width-1:0] w_op2;
    logic [1:0]       w_opc;

    // On a tie the requester that did not win last time takes the grant.
    always_comb begin
        w_grant_id = (req0_valid && req1_valid) ? ~r_last_grant : req1_valid;
        w_grant    = (r_state == StIdle) && !reset && (req0_valid || req1_valid);
        w_op1      = w_grant_id ? req1_op1 : req0_op1;
        w_op2      = w_grant_id ? req1_op2 : req0_op2;
        w_opc      = w_grant_id ? req1_opc : req0_opc;
    end

    assign req0_ready = w_grant && !w_grant_id;
    assign req1_ready = w_grant && w_grant_id;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= StIdle;
            r_last_grant <= 1'b1;
            r_opc        <= OpcAdd;
            r_id         <= 1'b0;
            r_alu_op1    <= '0;
            r_alu_op2    <= '0;
            r_alu_add    <= 1'b0;
            r_alu_sub    <= 1'b0;
            r_alu_cmp    <= 1'b0;
            r_rsp_valid  <= 1'b0;
            r_rsp_id     <= 1'b0;
            r_rsp_result <= '0;
            r_rsp_flags  <= '0;
            r_rsp_err    <= 1'b0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (w_grant) begin
                        r_alu_op1    <= w_op1;
                        r_alu_op2    <= w_op2;
                        r_opc        <= w_opc;
                        r_id         <= w_grant_id;
                        r_last_grant <= w_grant_id;
                        r_alu_add    <= (w_opc == OpcAdd);
                        r_alu_sub    <= (w_opc == OpcSub);
                        r_alu_cmp    <= (w_opc == OpcCmp);
                        r_state      <= StExec;
                    end
                end
                StExec: begin
                    r_alu_add   <= 1'b0;
                    r_alu_sub   <= 1'b0;
                    r_alu_cmp   <= 1'b0;
                    r_rsp_valid <= 1'b1;
                    r_rsp_id    <= r_id;
                    if (r_opc == OpcRsv) begin
                        r_rsp_result <= '0;
                        r_rsp_flags  <= '0;
                        r_rsp_err    <= 1'b1;
                    end else begin
                        r_rsp_result <= alu_result;
                        r_rsp_flags  <= {alu_c, alu_z, alu_n, alu_v};
                        r_rsp_err    <= 1'b0;
                    end
                    r_state <= StResp;
                end
                StResp: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign alu_op1    = r_alu_op1;
    assign alu_op2    = r_alu_op2;
    assign alu_add    = r_alu_add;
    assign alu_sub    = r_alu_sub;
    assign alu_cmp    = r_alu_cmp;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_id     = r_rsp_id;
    assign rsp_result = r_rsp_result;
    assign rsp_flags  = r_rsp_flags;
    assign rsp_err    = r_rsp_err;

endmodule

// File: tb/tb_setcc_arbiter.sv
// Scoreboard bench for setcc_arbiter: a behavioural setcc unit drives the ALU inputs,
// expected responses are queued at grant time and a monitor compares them as they appear.
module tb_setcc_arbiter;

    localparam int unsigned W = 32;
    localparam longint SMax = 64'sd2147483647;
    localparam longint SMin = -64'sd2147483648;

    logic         clk;
    logic         reset;
    logic         req0_valid, req0_ready, req1_valid, req1_ready;
    logic [W-1:0] req0_op1, req0_op2, req1_op1, req1_op2;
    logic [1:0]   req0_opc, req1_opc;
    logic [W-1:0] alu_op1, alu_op2;
    logic         alu_add, alu_sub, alu_cmp;
    logic [W:0]   alu_result;
    logic         alu_c, alu_z, alu_n, alu_v;
    logic         rsp_valid, rsp_ready, rsp_id, rsp_err;
    logic [W:0]   rsp_result;
    logic [3:0]   rsp_flags;

    setcc_arbiter #(.width(W)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_op1(req0_op1), .req0_op2(req0_op2), .req0_opc(req0_opc),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_op1(req1_op1), .req1_op2(req1_op2), .req1_opc(req1_opc),
        .alu_op1(alu_op1), .alu_op2(alu_op2),
        .alu_add(alu_add), .alu_sub(alu_sub), .alu_cmp(alu_cmp),
        .alu_result(alu_result), .alu_c(alu_c), .alu_z(alu_z), .alu_n(alu_n), .alu_v(alu_v),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_flags(rsp_flags), .rsp_err(rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural setcc unit; with no strobe it emits junk so a stray capture shows up.
    logic [W:0] sum, diff;
    always_comb begin
        sum        = {1'b0, alu_op1} + {1'b0, alu_op2};
        diff       = {1'b0, alu_op1} - {1'b0, alu_op2};
        alu_result = {1'b1, 32'h5A5A_A5A5};
        {alu_c, alu_z, alu_n, alu_v} = 4'hF;
        if (alu_add) begin
            alu_result = sum;
            {alu_c, alu_z, alu_n, alu_v} = {sum[W], sum == '0, sum[W-1],
                (alu_op1[W-1] == alu_op2[W-1]) && (sum[W-1] != alu_op1[W-1])};
        end else if (alu_sub || alu_cmp) begin
            alu_result = alu_sub ? diff : '0;
            {alu_c, alu_z, alu_n, alu_v} = {diff[W], diff == '0, diff[W-1],
                (alu_op1[W-1] != alu_op2[W-1]) && (diff[W-1] != alu_op1[W-1])};
        end
    end

    typedef struct packed {
        logic       id;
        logic [W:0] result;
        logic [3:0] flags;
        logic       err;
    } rsp_t;

    rsp_t         q[$];
    int           n_checks = 0;
    int           n_fail = 0;
    bit           tb_idle = 1'b1;
    bit           pop_seen = 1'b0;
    bit           exec_pend = 1'b0;
    bit           lat_pend = 1'b0;
    int           tb_last = 1;
    logic [W-1:0] ex_op1, ex_op2;
    logic [1:0]   ex_opc;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: signed overflow from exact integer range, unsigned carry/borrow from W+1 bits.
    function automatic rsp_t model(input logic id, input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic [1:0] opc);
        rsp_t   r;
        longint ua, ub, sa, sb, full, exact;
        ua = longint'(a);
        ub = longint'(b);
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        r.id = id;
        r.err = 1'b0;
        if (opc == 2'd3) begin
            r.result = '0;
            r.flags = '0;
            r.err = 1'b1;
            return r;
        end
        full = (opc == 2'd0) ? ua + ub : ua - ub;
        exact = (opc == 2'd0) ? sa + sb : sa - sb;
        r.result = full[W:0];
        r.flags = {r.result[W], r.result == '0, r.result[W-1], (exact > SMax) || (exact < SMin)};
        if (opc == 2'd2) r.result = '0;
        return r;
    endfunction

    always @(negedge clk) begin
        if (!reset) begin
            check("strobe_onehot", 64'($countones({alu_add, alu_sub, alu_cmp}) <= 1), 64'd1);
            if (rsp_valid) begin
                if (q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_rsp: got rsp_valid=1, expected no response pending");
                end else begin
                    check("rsp_id", 64'(rsp_id), 64'(q[0].id));
                    check("rsp_result", 64'(rsp_result), 64'(q[0].result));
                    check("rsp_flags", 64'(rsp_flags), 64'(q[0].flags));
                    check("rsp_err", 64'(rsp_err), 64'(q[0].err));
                    if (rsp_ready) begin
                        void'(q.pop_front());
                        pop_seen = 1'b1;
                    end
                end
            end
        end
    end

    // One clock: checks at negedge, returns the expected grant (-1 none), ends at posedge+1.
    task automatic step(output int g);
        logic [1:0] exp_rdy;
        bit         exp_idle;
        @(negedge clk);
        #1;
        if (lat_pend) begin
            check("latency_rsp_valid", 64'(rsp_valid), 64'd1);
            lat_pend = 1'b0;
        end
        if (exec_pend) begin
            check("exec_rsp_valid", 64'(rsp_valid), 64'd0);
            check("exec_op1", 64'(alu_op1), 64'(ex_op1));
            check("exec_op2", 64'(alu_op2), 64'(ex_op2));
            check("exec_strobes", 64'({alu_add, alu_sub, alu_cmp}),
                  64'((ex_opc == 2'd0) ? 3'b100 : (ex_opc == 2'd1) ? 3'b010 :
                      (ex_opc == 2'd2) ? 3'b001 : 3'b000));
            exec_pend = 1'b0;
            lat_pend = 1'b1;
        end
        exp_idle = tb_idle;
        if (pop_seen) begin
            tb_idle = 1'b1;
            pop_seen = 1'b0;
        end
        g = -1;
        if (exp_idle && (req0_valid || req1_valid))
            g = (req0_valid && req1_valid) ? 1 - tb_last : (req1_valid ? 1 : 0);
        exp_rdy = (g == 0) ? 2'b01 : (g == 1) ? 2'b10 : 2'b00;
        check("grant", 64'({req1_ready, req0_ready}), 64'(exp_rdy));
        if (g >= 0) begin
            ex_op1 = (g == 1) ? req1_op1 : req0_op1;
            ex_op2 = (g == 1) ? req1_op2 : req0_op2;
            ex_opc = (g == 1) ? req1_opc : req0_opc;
            q.push_back(model(g[0], ex_op1, ex_op2, ex_opc));
            tb_last = g;
            tb_idle = 1'b0;
            exec_pend = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic clear_model();
        q.delete();
        tb_idle = 1'b1;
        pop_seen = 1'b0;
        exec_pend = 1'b0;
        lat_pend = 1'b0;
        tb_last = 1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clear_model();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic set_req(input int n, input logic v, input logic [W-1:0] a,
                           input logic [W-1:0] b, input logic [1:0] opc);
        if (n == 0) begin
            req0_valid = v; req0_op1 = a; req0_op2 = b; req0_opc = opc;
        end else begin
            req1_valid = v; req1_op1 = a; req1_op2 = b; req1_opc = opc;
        end
    endtask

    function automatic logic [W-1:0] rand_op();
        case ($urandom_range(0, 5))
            0: return '0;
            1: return 32'd1;
            2: return 32'h7FFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int g;
        int grants;
        reset = 1'b1;
        rsp_ready = 1'b0;
        set_req(0, 1'b1, 32'd3, 32'd4, 2'd0);
        set_req(1, 1'b1, 32'd5, 32'd6, 2'd1);
        repeat (2) @(posedge clk);
        #1;
        check("reset_ready", 64'({req1_ready, req0_ready}), 64'd0);
        check("reset_alu_ops", 64'({alu_op1, alu_op2}), 64'd0);
        check("reset_strobes", 64'({alu_add, alu_sub, alu_cmp}), 64'd0);
        check("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        check("reset_rsp_fields", 64'({rsp_id, rsp_result, rsp_flags, rsp_err}), 64'd0);
        set_req(0, 1'b0, '0, '0, 2'd0);
        set_req(1, 1'b0, '0, '0, 2'd0);
        clear_model();
        reset = 1'b0;

        // Single add with carry out.
        rsp_ready = 1'b1;
        set_req(0, 1'b1, 32'hFFFF_FFFF, 32'd1, 2'd0);
        step(g);
        set_req(0, 1'b0, '0, '0, 2'd0);
        repeat (4) step(g);

        // Tie after reset: 0,1,0,1.
        do_reset();
        set_req(0, 1'b1, 32'd5, 32'd3, 2'd1);
        set_req(1, 1'b1, 32'd5, 32'd3, 2'd1);
        grants = 0;
        for (int i = 0; i < 16 && grants < 4; i++) begin
            step(g);
            if (g >= 0) grants++;
        end
        check("tie_grant_count", 64'(grants), 64'd4);
        set_req(0, 1'b0, '0, '0, 2'd0);
        set_req(1, 1'b0, '0, '0, 2'd0);
        repeat (4) step(g);

        // Backpressure: compare held for 10 cycles, req1 waits.
        rsp_ready = 1'b0;
        set_req(0, 1'b1, 32'd7, 32'd7, 2'd2);
        step(g);
        set_req(0, 1'b0, '0, '0, 2'd0);
        set_req(1, 1'b1, 32'd10, 32'd20, 2'd0);
        repeat (10) step(g);
        rsp_ready = 1'b1;
        step(g);
        step(g);
        check("bp_req1_granted", 64'(req1_ready), 64'd0);
        set_req(1, 1'b0, '0, '0, 2'd0);
        repeat (4) step(g);

        // Reserved opcode from requester 1.
        set_req(1, 1'b1, 32'h1234_5678, 32'h0000_0042, 2'd3);
        step(g);
        set_req(1, 1'b0, '0, '0, 2'd0);
        repeat (4) step(g);

        // Signed overflow on subtract.
        set_req(0, 1'b1, 32'h8000_0000, 32'd1, 2'd1);
        step(g);
        set_req(0, 1'b0, '0, '0, 2'd0);
        repeat (4) step(g);

        // Reset while in EXEC discards the operation.
        set_req(0, 1'b1, 32'd100, 32'd1, 2'd0);
        set_req(1, 1'b1, 32'd200, 32'd2, 2'd0);
        step(g);
        reset = 1'b1;
        clear_model();
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("midreset_rsp_valid", 64'(rsp_valid), 64'd0);
        check("midreset_strobes", 64'({alu_add, alu_sub, alu_cmp}), 64'd0);
        check("midreset_alu_op1", 64'(alu_op1), 64'd0);
        step(g);
        set_req(0, 1'b0, '0, '0, 2'd0);
        set_req(1, 1'b0, '0, '0, 2'd0);
        repeat (4) step(g);

        // Randomized traffic with random backpressure and withdrawn requests.
        for (int i = 0; i < 400; i++) begin
            step(g);
            for (int n = 0; n < 2; n++) begin
                if (g == n || (n == 0 ? !req0_valid : !req1_valid))
                    set_req(n, 1'($urandom_range(0, 1)), rand_op(), rand_op(),
                            2'($urandom_range(0, 3)));
                else if ($urandom_range(0, 9) == 0)
                    set_req(n, 1'b0, rand_op(), rand_op(), 2'($urandom_range(0, 3)));
            end
            rsp_ready = ($urandom_range(0, 9) < 7);
        end

        set_req(0, 1'b0, '0, '0, 2'd0);
        set_req(1, 1'b0, '0, '0, 2'd0);
        rsp_ready = 1'b1;
        for (int i = 0; i < 20 && (q.size() != 0 || exec_pend || lat_pend); i++) step(g);
        check("drain_empty", 64'(q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
